// File: rtl/dlsc_axi_router_rd_response_pkg.sv
// Shared AXI router definitions: R/B response encodings and R payload layout.
// R payload is packed MSB..LSB as {last, resp, data}.
package dlsc_axi_router_rd_response_pkg;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_t;

  localparam int unsigned AXI_RESP_W = 2;

  // Width of a packed R payload for a given data width.
  function automatic int unsigned r_payload_w(input int unsigned data_w);
    return data_w + AXI_RESP_W + 1;
  endfunction

endpackage

// File: rtl/dlsc_axi_router_rd_response_if.sv
// Bundle of the rd_response block's command and R-channel signals.
// slave  : router view (consumes cmd_*, out_r_* payload, in_r_ready)
// master : environment view (command block, slaves and masters)
interface dlsc_axi_router_rd_response_if #(
  parameter int unsigned DATA     = 32,
  parameter int unsigned INPUTS   = 1,
  parameter int unsigned INPUTSB  = 1,
  parameter int unsigned OUTPUTS  = 1,
  parameter int unsigned OUTPUTSB = 1
);
  import dlsc_axi_router_rd_response_pkg::*;

  logic [INPUTS-1:0]              cmd_full_input;
  logic [OUTPUTS-1:0]             cmd_full_output;
  logic                           cmd_push;
  logic [INPUTS-1:0]              cmd_input_onehot;
  logic [OUTPUTS-1:0]             cmd_output_onehot;
  logic [INPUTSB-1:0]             cmd_input;
  logic [OUTPUTSB-1:0]            cmd_output;

  logic [OUTPUTS-1:0]             out_r_ready;
  logic [OUTPUTS-1:0]             out_r_valid;
  logic [OUTPUTS-1:0]             out_r_last;
  logic [OUTPUTS*DATA-1:0]        out_r_data;
  logic [OUTPUTS*AXI_RESP_W-1:0]  out_r_resp;

  logic [INPUTS-1:0]              in_r_ready;
  logic [INPUTS-1:0]              in_r_valid;
  logic [INPUTS-1:0]              in_r_last;
  logic [INPUTS*DATA-1:0]         in_r_data;
  logic [INPUTS*AXI_RESP_W-1:0]   in_r_resp;

  modport slave (
    output cmd_full_input, cmd_full_output, out_r_ready,
           in_r_valid, in_r_last, in_r_data, in_r_resp,
    input  cmd_push, cmd_input_onehot, cmd_output_onehot, cmd_input, cmd_output,
           out_r_valid, out_r_last, out_r_data, out_r_resp, in_r_ready
  );

  modport master (
    input  cmd_full_input, cmd_full_output, out_r_ready,
           in_r_valid, in_r_last, in_r_data, in_r_resp,
    output cmd_push, cmd_input_onehot, cmd_output_onehot, cmd_input, cmd_output,
           out_r_valid, out_r_last, out_r_data, out_r_resp, in_r_ready
  );

endinterface

// File: rtl/dlsc_axi_router_cmdfifo.sv
// Small command FIFO with a registered almost_full (occupancy >= DEPTH-1).
// Ports: clk/rst (sync, active-high), push/push_data write, pop advances head,
// empty/head show the oldest entry, almost_full registered.
module dlsc_axi_router_cmdfifo #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DEPTHB = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic             almost_full
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTHB-1:0] wr_ptr;
  logic [DEPTHB-1:0] rd_ptr;
  logic [DEPTHB:0]   cnt;
  logic [DEPTHB:0]   cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (push && !pop)      cnt_next = cnt + (DEPTHB+1)'(1);
    else if (!push && pop) cnt_next = cnt - (DEPTHB+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTHB'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTHB'(1);
      cnt         <= cnt_next;
      almost_full <= (cnt_next >= (DEPTHB+1)'(DEPTH-1));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && cnt == (DEPTHB+1)'(DEPTH)))
        else $error("dlsc_axi_router_cmdfifo: push into full FIFO");
    end
  end

  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/dlsc_axi_router_rd_response.sv
// AXI router R-channel return path. Records routed read commands in per-master
// (IQ) and per-slave (OQ) FIFOs and connects master i to slave o whenever each
// FIFO's head names the other. R beats pass combinationally over that link; a
// last beat handshake pops both heads.
// Ports: clk, rst (sync, active-high), bus (slave modport: cmd_* interface from
// the command block, out_r_* to/from slaves, in_r_* to/from masters).
module dlsc_axi_router_rd_response
  import dlsc_axi_router_rd_response_pkg::*;
#(
  parameter int unsigned DATA     = 32,
  parameter int unsigned INPUTS   = 1,
  parameter int unsigned INPUTSB  = 1,
  parameter int unsigned OUTPUTS  = 1,
  parameter int unsigned OUTPUTSB = 1,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DEPTHB   = 2
) (
  input logic                          clk,
  input logic                          rst,
  dlsc_axi_router_rd_response_if.slave bus
);

  localparam int unsigned PW = r_payload_w(DATA);

  logic [INPUTS-1:0]   iq_empty, iq_pop, iq_push, full_in;
  logic [OUTPUTSB-1:0] iq_head [INPUTS];
  logic [OUTPUTS-1:0]  oq_empty, oq_pop, oq_push, full_out;
  logic [INPUTSB-1:0]  oq_head [OUTPUTS];

  logic [PW-1:0]       out_pl [OUTPUTS];
  logic [INPUTS-1:0]   in_valid, in_last;
  logic [INPUTS*DATA-1:0]       in_data;
  logic [INPUTS*AXI_RESP_W-1:0] in_resp;
  logic [OUTPUTS-1:0]  out_ready;
  logic [INPUTS-1:0][OUTPUTS-1:0] link;

  for (genvar gi = 0; gi < INPUTS; gi++) begin : g_iq
    assign iq_push[gi] = bus.cmd_push & bus.cmd_input_onehot[gi];
    dlsc_axi_router_cmdfifo #(.WIDTH(OUTPUTSB), .DEPTH(DEPTH), .DEPTHB(DEPTHB)) u_fifo (
      .clk(clk), .rst(rst), .push(iq_push[gi]), .push_data(bus.cmd_output),
      .pop(iq_pop[gi]), .empty(iq_empty[gi]), .head(iq_head[gi]),
      .almost_full(full_in[gi])
    );
  end

  for (genvar go = 0; go < OUTPUTS; go++) begin : g_oq
    assign oq_push[go] = bus.cmd_push & bus.cmd_output_onehot[go];
    dlsc_axi_router_cmdfifo #(.WIDTH(INPUTSB), .DEPTH(DEPTH), .DEPTHB(DEPTHB)) u_fifo (
      .clk(clk), .rst(rst), .push(oq_push[go]), .push_data(bus.cmd_input),
      .pop(oq_pop[go]), .empty(oq_empty[go]), .head(oq_head[go]),
      .almost_full(full_out[go])
    );
    assign out_pl[go] = {bus.out_r_last[go],
                         bus.out_r_resp[go*AXI_RESP_W +: AXI_RESP_W],
                         bus.out_r_data[go*DATA +: DATA]};
  end

  // Mutual head match makes links a partial permutation, so OR-ing across
  // the matrix never merges two sources.
  always_comb begin
    link = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      for (int unsigned o = 0; o < OUTPUTS; o++) begin
        link[i][o] = !iq_empty[i] && !oq_empty[o] &&
                     (iq_head[i] == OUTPUTSB'(o)) && (oq_head[o] == INPUTSB'(i));
      end
    end
  end

  always_comb begin
    logic [PW-1:0] pl;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    in_resp   = '0;
    out_ready = '0;
    iq_pop    = '0;
    oq_pop    = '0;
    pl        = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      for (int unsigned o = 0; o < OUTPUTS; o++) begin
        if (link[i][o]) begin
          pl                                 = out_pl[o];
          in_valid[i]                        = bus.out_r_valid[o];
          out_ready[o]                       = bus.in_r_ready[i];
          in_last[i]                         = pl[PW-1];
          in_resp[i*AXI_RESP_W +: AXI_RESP_W] = pl[DATA +: AXI_RESP_W];
          in_data[i*DATA +: DATA]            = pl[DATA-1:0];
          if (bus.out_r_valid[o] && bus.in_r_ready[i] && bus.out_r_last[o]) begin
            iq_pop[i] = 1'b1;
            oq_pop[o] = 1'b1;
          end
        end
      end
    end
  end

  assign bus.cmd_full_input  = full_in;
  assign bus.cmd_full_output = full_out;
  assign bus.out_r_ready     = out_ready;
  assign bus.in_r_valid      = in_valid;
  assign bus.in_r_last       = in_last;
  assign bus.in_r_data       = in_data;
  assign bus.in_r_resp       = in_resp;

endmodule

// File: tb/tb_dlsc_axi_router_rd_response.sv
module tb_dlsc_axi_router_rd_response;
  import dlsc_axi_router_rd_response_pkg::*;

  localparam int unsigned DATA  = 32;
  localparam int unsigned NI    = 2;
  localparam int unsigned NO    = 2;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dlsc_axi_router_rd_response_if #(
    .DATA(DATA), .INPUTS(NI), .INPUTSB(1), .OUTPUTS(NO), .OUTPUTSB(1)
  ) bus ();

  dlsc_axi_router_rd_response #(
    .DATA(DATA), .INPUTS(NI), .INPUTSB(1), .OUTPUTS(NO), .OUTPUTSB(1),
    .DEPTH(DEPTH), .DEPTHB(2)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Reference model: per-master queue of destination slaves, per-slave queue
  // of source masters, in push order.
  int iq [NI][$];
  int oq [NO][$];
  int delivered [NI];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slave currently serving master i, or -1.
  function automatic int linked_slave(input int i);
    int o;
    if (iq[i].size() == 0) return -1;
    o = iq[i][0];
    if (oq[o].size() != 0 && oq[o][0] == i) return o;
    return -1;
  endfunction

  task automatic idle();
    bus.cmd_push          = 1'b0;
    bus.cmd_input_onehot  = '0;
    bus.cmd_output_onehot = '0;
    bus.cmd_input         = '0;
    bus.cmd_output        = '0;
    bus.out_r_valid       = '0;
    bus.out_r_last        = '0;
    bus.out_r_data        = '0;
    bus.out_r_resp        = '0;
    bus.in_r_ready        = '0;
  endtask

  task automatic push(input int i, input int o);
    bus.cmd_push          = 1'b1;
    bus.cmd_input_onehot  = '0;
    bus.cmd_output_onehot = '0;
    bus.cmd_input_onehot[i]  = 1'b1;
    bus.cmd_output_onehot[o] = 1'b1;
    bus.cmd_input         = 1'(i);
    bus.cmd_output        = 1'(o);
  endtask

  task automatic set_r(input int o, input logic v, input logic l);
    bus.out_r_valid[o]             = v;
    bus.out_r_last[o]              = l;
    bus.out_r_data[o*DATA +: DATA] = $urandom;
    bus.out_r_resp[o*2 +: 2]       = 2'($urandom_range(0, 3));
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the
  // model by what the clock edge will do.
  task automatic step();
    int o;
    int pop_i [$];
    logic [NO-1:0] exp_ready;
    @(negedge clk);
    if (!rst) begin
      exp_ready = '0;
      for (int i = 0; i < NI; i++) begin
        o = linked_slave(i);
        if (o < 0) begin
          check($sformatf("valid%0d_nolink", i), bus.in_r_valid[i], 1'b0);
        end else begin
          check($sformatf("valid%0d", i), bus.in_r_valid[i], bus.out_r_valid[o]);
          if (bus.out_r_valid[o]) begin
            check($sformatf("data%0d", i), bus.in_r_data[i*DATA +: DATA], bus.out_r_data[o*DATA +: DATA]);
            check($sformatf("resp%0d", i), bus.in_r_resp[i*2 +: 2], bus.out_r_resp[o*2 +: 2]);
            check($sformatf("last%0d", i), bus.in_r_last[i], bus.out_r_last[o]);
          end
          exp_ready[o] = bus.in_r_ready[i];
          if (bus.out_r_valid[o] && bus.in_r_ready[i]) begin
            delivered[i]++;
            if (bus.out_r_last[o]) pop_i.push_back(i);
          end
        end
        check($sformatf("full_in%0d", i), bus.cmd_full_input[i], iq[i].size() >= DEPTH-1);
      end
      for (int k = 0; k < NO; k++) begin
        check($sformatf("ready%0d", k), bus.out_r_ready[k], exp_ready[k]);
        check($sformatf("full_out%0d", k), bus.cmd_full_output[k], oq[k].size() >= DEPTH-1);
      end
    end
    if (rst) begin
      for (int i = 0; i < NI; i++) iq[i].delete();
      for (int k = 0; k < NO; k++) oq[k].delete();
    end else begin
      foreach (pop_i[n]) begin
        o = iq[pop_i[n]].pop_front();
        void'(oq[o].pop_front());
      end
      if (bus.cmd_push) begin
        iq[int'(bus.cmd_input)].push_back(int'(bus.cmd_output));
        oq[int'(bus.cmd_output)].push_back(int'(bus.cmd_input));
      end
    end
    @(posedge clk);
    #1;
    bus.cmd_push = 1'b0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NI; i++) delivered[i] = 0;
  endtask

  initial begin
    int i, o;
    idle();
    clear_counts();
    rst = 1'b1;
    step();
    step();
    check("rst_in_valid", bus.in_r_valid, '0);
    check("rst_out_ready", bus.out_r_ready, '0);
    check("rst_full_in", bus.cmd_full_input, '0);
    check("rst_full_out", bus.cmd_full_output, '0);
    rst = 1'b0;

    // Single 4-beat burst o1 -> i0
    push(0, 1); step(); clear_counts();
    bus.in_r_ready[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      set_r(1, 1'b1, b == 3);
      step();
    end
    set_r(1, 1'b1, 1'b0);
    step();
    check("t1_beats", delivered[0], 4);
    idle();

    // i0 waits for o0 before o1
    push(0, 0); step(); push(0, 1); step();
    bus.in_r_ready[0] = 1'b1;
    set_r(1, 1'b1, 1'b1);
    step(); step();
    check("t2_o1_stalled", bus.out_r_ready[1], 1'b0);
    set_r(0, 1'b1, 1'b0); step();
    set_r(0, 1'b1, 1'b1); step();
    bus.out_r_valid[0] = 1'b0;
    check("t2_o1_ready", bus.out_r_ready[1], 1'b1);
    step();
    idle(); step();

    // o0 serves i0 then i1
    push(0, 0); step(); push(1, 0); step(); clear_counts();
    bus.in_r_ready = '1;
    for (int b = 0; b < 4; b++) begin
      set_r(0, 1'b1, b[0]);
      step();
    end
    check("t3_i0_beats", delivered[0], 2);
    check("t3_i1_beats", delivered[1], 2);
    idle(); step();

    // almost_full threshold, 4th push, simultaneous push/pop
    for (int n = 0; n < 3; n++) begin push(0, 0); step(); end
    check("t4_full_in", bus.cmd_full_input[0], 1'b1);
    check("t4_full_out", bus.cmd_full_output[0], 1'b1);
    push(0, 0); step();
    bus.in_r_ready[0] = 1'b1;
    set_r(0, 1'b1, 1'b1); step();
    check("t4_full_occ3", bus.cmd_full_input[0], 1'b1);
    push(0, 0); set_r(0, 1'b1, 1'b1); step();
    check("t6_full_pushpop", bus.cmd_full_input[0], 1'b1);
    set_r(0, 1'b1, 1'b1); step();
    bus.out_r_valid[0] = 1'b0; step();
    check("t4_full_occ2", bus.cmd_full_input[0], 1'b0);
    check("t4_fullo_occ2", bus.cmd_full_output[0], 1'b0);

    // Reset mid-burst
    set_r(0, 1'b1, 1'b0);
    rst = 1'b1; step();
    check("t6_rst_valid", bus.in_r_valid, '0);
    check("t6_rst_ready", bus.out_r_ready, '0);
    check("t6_rst_data", bus.in_r_data, '0);
    check("t6_rst_full", {bus.cmd_full_input, bus.cmd_full_output}, '0);
    rst = 1'b0; step();
    idle(); step();

    // Master back-pressure for 5 cycles mid-burst
    push(0, 1); step(); clear_counts();
    bus.in_r_ready[0] = 1'b1;
    set_r(1, 1'b1, 1'b0); step(); step();
    bus.in_r_ready[0] = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      check("t5_stall_ready", bus.out_r_ready[1], 1'b0);
    end
    check("t5_stall_beats", delivered[0], 2);
    bus.in_r_ready[0] = 1'b1;
    step();
    set_r(1, 1'b1, 1'b1); step();
    check("t5_beats", delivered[0], 4);
    idle(); step();

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        i = int'($urandom_range(0, NI-1));
        o = int'($urandom_range(0, NO-1));
        if (iq[i].size() < DEPTH && oq[o].size() < DEPTH) push(i, o);
      end
      for (int k = 0; k < NO; k++)
        set_r(k, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
      for (int k = 0; k < NI; k++)
        bus.in_r_ready[k] = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
